excitation_gen: RTL and testbench

Source-excitation stage for the vocoder synthesis path. It consumes the free-running 31-bit LFSR noise word and produces one signed excitation sample per audio sample tick. In voiced mode the sample is a gain-scaled pulse train at the commanded pitch period; in unvoiced mode it is gain-scaled noise. Its output feeds the downstream vocal-tract filter.

---
 rtl/excitation_pkg.sv | 29 ++
 rtl/excitation_gen_if.sv | 33 +++
 rtl/excitation_pulse_shaper.sv | 40 ++++
 rtl/excitation_gen.sv | 124 ++++++++++++
 tb/tb_excitation_gen.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/excitation_pkg.sv
// +----------------------------------------------------------------------------+
// | excitation_pkg                                                             |
// | Shared types and constants for the excitation generator.                   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package excitation_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        VOICED   = 2'd1,
        UNVOICED = 2'd2
    } exc_state_e;

    localparam int MIN_PERIOD     = 2;
    localparam int DEF_OUT_WIDTH  = 16;
    localparam int DEF_GAIN_WIDTH = 8;

    // Left shift that puts the gain MSB just below the output sign bit.
    function automatic int pulse_shift(input int out_w, input int gain_w);
        return out_w - 1 - gain_w;
    endfunction

    localparam int PULSE_SHIFT = pulse_shift(DEF_OUT_WIDTH, DEF_GAIN_WIDTH);

endpackage

`default_nettype wire

// File: rtl/excitation_gen_if.sv
// +----------------------------------------------------------------------------+
// | excitation_gen_if                                                          |
// | Control, noise and sample-output bundle of the excitation generator.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface excitation_gen_if #(
    parameter int OUT_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 16,
    parameter int GAIN_WIDTH   = 8
);
    logic [30:0]                   noise_in;
    logic                          sample_tick_in;
    logic                          enable_in;
    logic                          voiced_in;
    logic [PERIOD_WIDTH-1:0]       pitch_period_in;
    logic [GAIN_WIDTH-1:0]         gain_in;
    logic signed [OUT_WIDTH-1:0]   excitation_out;
    logic                          valid_out;

    modport master (
        output noise_in, sample_tick_in, enable_in, voiced_in, pitch_period_in, gain_in,
        input  excitation_out, valid_out
    );

    modport slave (
        input  noise_in, sample_tick_in, enable_in, voiced_in, pitch_period_in, gain_in,
        output excitation_out, valid_out
    );
endinterface

`default_nettype wire

// File: rtl/excitation_pulse_shaper.sv
// +----------------------------------------------------------------------------+
// | excitation_pulse_shaper                                                    |
// | Maps (period counter, gain) to the voiced sample. EXCITATION_GLOTTAL_EN    |
// | selects a 4-sample decaying pulse instead of a single impulse.             |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module excitation_pulse_shaper
    import excitation_pkg::*;
#(
    parameter int OUT_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 16,
    parameter int GAIN_WIDTH   = 8
) (
    input  wire logic [PERIOD_WIDTH-1:0]     cnt_i,
    input  wire logic [GAIN_WIDTH-1:0]       gain_i,
    output logic signed [OUT_WIDTH-1:0]      sample_o
);

    localparam int SHIFT = pulse_shift(OUT_WIDTH, GAIN_WIDTH);

    logic signed [OUT_WIDTH-1:0] w_amp;

    assign w_amp = $signed(OUT_WIDTH'(gain_i) << SHIFT);

`ifdef EXCITATION_GLOTTAL_EN
    always_comb begin
        sample_o = '0;
        if (cnt_i < PERIOD_WIDTH'(4)) begin
            sample_o = w_amp >>> cnt_i[1:0];
        end
    end
`else
    assign sample_o = (cnt_i == '0) ? w_amp : '0;
`endif

endmodule

`default_nettype wire

// File: rtl/excitation_gen.sv
// +----------------------------------------------------------------------------+
// | excitation_gen                                                             |
// | Per-tick pulse-train / scaled-noise excitation source. Optional glottal    |
// | pulse shaping via EXCITATION_GLOTTAL_EN (see excitation_pulse_shaper).     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module excitation_gen
    import excitation_pkg::*;
#(
    parameter int OUT_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 16,
    parameter int GAIN_WIDTH   = 8
) (
    input  wire logic        clk_in,
    input  wire logic        rst_in,
    excitation_gen_if.slave  bus
);

    localparam int PROD_W = 16 + GAIN_WIDTH + 1;

    exc_state_e                   state_q;
    logic [PERIOD_WIDTH-1:0]      cnt_q;
    logic [PERIOD_WIDTH-1:0]      period_q;
    logic signed [OUT_WIDTH-1:0]  exc_q;
    logic                         valid_q;

    logic                         w_wrap;
    logic [PERIOD_WIDTH-1:0]      w_period_new;
    logic [PERIOD_WIDTH-1:0]      w_pulse_cnt;
    logic signed [OUT_WIDTH-1:0]  w_pulse;
    logic signed [PROD_W-1:0]     w_prod;
    logic signed [PROD_W-1:0]     w_scaled;
    logic signed [OUT_WIDTH-1:0]  w_noise;
    logic                         w_unused;

    assign w_wrap       = (cnt_q == period_q - PERIOD_WIDTH'(1));
    assign w_period_new = (bus.pitch_period_in < PERIOD_WIDTH'(MIN_PERIOD)) ?
                          PERIOD_WIDTH'(MIN_PERIOD) : bus.pitch_period_in;

    // Counter value the voiced sample on this tick is computed for.
    assign w_pulse_cnt  = (state_q == VOICED && !w_wrap) ? cnt_q + PERIOD_WIDTH'(1) : '0;

    excitation_pulse_shaper #(
        .OUT_WIDTH    (OUT_WIDTH),
        .PERIOD_WIDTH (PERIOD_WIDTH),
        .GAIN_WIDTH   (GAIN_WIDTH)
    ) u_shaper (
        .cnt_i    (w_pulse_cnt),
        .gain_i   (bus.gain_in),
        .sample_o (w_pulse)
    );

    // Signed noise times zero-extended gain; |n|*gain/2^GAIN_WIDTH always fits.
    assign w_prod   = PROD_W'($signed(bus.noise_in[30:15])) * PROD_W'($signed({1'b0, bus.gain_in}));
    assign w_scaled = w_prod >>> GAIN_WIDTH;
    assign w_noise  = w_scaled[OUT_WIDTH-1:0];
    assign w_unused = ^{bus.noise_in[14:0], w_scaled[PROD_W-1:OUT_WIDTH]};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= PERIOD_WIDTH'(MIN_PERIOD);
            exc_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= bus.sample_tick_in;
            if (bus.sample_tick_in) begin
                if (!bus.enable_in) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    exc_q   <= '0;
                end else begin
                    case (state_q)
                        VOICED: begin
                            if (w_wrap) begin
                                cnt_q    <= '0;
                                period_q <= w_period_new;
                                if (bus.voiced_in) begin
                                    exc_q <= w_pulse;
                                end else begin
                                    state_q <= UNVOICED;
                                    exc_q   <= w_noise;
                                end
                            end else begin
                                cnt_q <= cnt_q + PERIOD_WIDTH'(1);
                                exc_q <= w_pulse;
                            end
                        end
                        UNVOICED: begin
                            if (bus.voiced_in) begin
                                state_q  <= VOICED;
                                cnt_q    <= '0;
                                period_q <= w_period_new;
                                exc_q    <= w_pulse;
                            end else begin
                                exc_q <= w_noise;
                            end
                        end
                        default: begin
                            cnt_q    <= '0;
                            period_q <= w_period_new;
                            if (bus.voiced_in) begin
                                state_q <= VOICED;
                                exc_q   <= w_pulse;
                            end else begin
                                state_q <= UNVOICED;
                                exc_q   <= w_noise;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign bus.excitation_out = exc_q;
    assign bus.valid_out      = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_excitation_gen.sv
// +----------------------------------------------------------------------------+
// | tb_excitation_gen                                                          |
// | Directed self-checking bench for excitation_gen (honours                   |
// | EXCITATION_GLOTTAL_EN for voiced expectations).                            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_excitation_gen;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_in = ~clk_in;

    excitation_gen_if #(.OUT_WIDTH(16), .PERIOD_WIDTH(16), .GAIN_WIDTH(8)) bus ();

    excitation_gen #(.OUT_WIDTH(16), .PERIOD_WIDTH(16), .GAIN_WIDTH(8)) u_dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    // Voiced sample at gain 255 for a given counter value.
    function automatic int vexp(input int cnt);
`ifdef EXCITATION_GLOTTAL_EN
        case (cnt)
            0:       return 32640;
            1:       return 16320;
            2:       return 8160;
            3:       return 4080;
            default: return 0;
        endcase
`else
        return (cnt == 0) ? 32640 : 0;
`endif
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One isolated tick: strobe + sample, then a gap cycle with held output.
    task automatic do_tick(input string tag, input int exp);
        @(negedge clk_in);
        bus.sample_tick_in = 1'b1;
        @(posedge clk_in);
        #1;
        bus.sample_tick_in = 1'b0;
        check({tag, ".valid"}, bus.valid_out, 1);
        check(tag, bus.excitation_out, exp);
        @(posedge clk_in);
        #1;
        check({tag, ".gap"}, bus.valid_out, 0);
        check({tag, ".hold"}, bus.excitation_out, exp);
    endtask

    initial begin
        int cs5 [12];
        int b2b [4];
        cs5 = '{0, 1, 2, 3, 4, 0, 1, 2, 0, 1, 2, 0};
        b2b = '{vexp(0), vexp(1), vexp(0), vexp(1)};

        bus.noise_in        = '0;
        bus.sample_tick_in  = 1'b0;
        bus.enable_in       = 1'b0;
        bus.voiced_in       = 1'b0;
        bus.pitch_period_in = '0;
        bus.gain_in         = '0;

        #12;
        check("rst.out",   bus.excitation_out, 0);
        check("rst.valid", bus.valid_out,      0);
        @(negedge clk_in);
        rst_in = 1'b1;

        for (int i = 0; i < 5; i++) do_tick($sformatf("dis_%0d", i), 0);

        // Voiced impulse train, P=4
        bus.enable_in = 1'b1; bus.voiced_in = 1'b1;
        bus.pitch_period_in = 16'd4; bus.gain_in = 8'd255;
        for (int i = 0; i < 8; i++) do_tick($sformatf("p4_%0d", i), vexp(i % 4));
        bus.enable_in = 1'b0; do_tick("p4_off", 0);

        // P=5, new period 3 presented at the second tick
        bus.enable_in = 1'b1; bus.pitch_period_in = 16'd5;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) bus.pitch_period_in = 16'd3;
            do_tick($sformatf("p5_%0d", i), vexp(cs5[i]));
        end
        bus.enable_in = 1'b0; do_tick("p5_off", 0);

        // Unvoiced noise scaling
        bus.enable_in = 1'b1; bus.voiced_in = 1'b0;
        bus.gain_in = 8'd128; bus.noise_in = {16'h8000, 15'h1234};
        do_tick("uv_g128", -16384);
        bus.gain_in = 8'd0;   do_tick("uv_g0", 0);
        bus.gain_in = 8'd255; bus.noise_in = {16'h7FFF, 15'h2AAA};
        do_tick("uv_max", 32639);
        bus.gain_in = 8'd1;   bus.noise_in = {16'hFFFD, 15'h0001};
        do_tick("uv_neg", -1);
        bus.enable_in = 1'b0; do_tick("uv_off", 0);

        // Voiced -> unvoiced at counter 1, then back to voiced
        bus.enable_in = 1'b1; bus.voiced_in = 1'b1;
        bus.pitch_period_in = 16'd4; bus.gain_in = 8'd255;
        bus.noise_in = {16'h8000, 15'h0000};
        do_tick("vu_0", vexp(0));
        bus.voiced_in = 1'b0;
        do_tick("vu_1", vexp(1));
        do_tick("vu_2", vexp(2));
        do_tick("vu_3", vexp(3));
        do_tick("vu_wrap_noise", -32640);
        bus.voiced_in = 1'b1;
        do_tick("uv_to_v", 32640);
        do_tick("uv_to_v_1", vexp(1));
        bus.enable_in = 1'b0; do_tick("vu_off", 0);

        // Period 0 clamps to 2; back-to-back ticks
        bus.enable_in = 1'b1; bus.pitch_period_in = 16'd0;
        @(negedge clk_in);
        bus.sample_tick_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_in);
            #1;
            check($sformatf("b2b_%0d.valid", i), bus.valid_out, 1);
            check($sformatf("b2b_%0d", i), bus.excitation_out, b2b[i]);
        end
        bus.sample_tick_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("b2b.gap", bus.valid_out, 0);
        bus.enable_in = 1'b0; do_tick("b2b_off", 0);

        // P=6 shape, gain change at wrap
        bus.enable_in = 1'b1; bus.pitch_period_in = 16'd6;
        for (int i = 0; i < 6; i++) do_tick($sformatf("p6_%0d", i), vexp(i));
        bus.gain_in = 8'd1;
        do_tick("p6_gain1", 128);

        // Asynchronous reset mid-period
        @(negedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        check("mid_rst.out",   bus.excitation_out, 0);
        check("mid_rst.valid", bus.valid_out,      0);
        @(negedge clk_in);
        rst_in = 1'b1;
        bus.gain_in = 8'd255;
        do_tick("post_rst_0", 32640);
        do_tick("post_rst_1", vexp(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
